// File: rtl/instr_encoder.sv
// Streaming Frost32 instruction encoder: field-level requests in, packed 32-bit words out.
// Define INSTR_ENCODER_PSEUDO_LI_EN to build the two-word "li rA, imm32" expansion.
module instr_encoder #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           in_group,
    input  logic [3:0]           in_opcode,
    input  logic [3:0]           in_ra,
    input  logic [3:0]           in_rb,
    input  logic [3:0]           in_rc,
    input  logic [31:0]          in_imm,
    input  logic                 in_pseudo_li,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_word,
    output logic                 out_last,
    output logic                 err,
    output logic [1:0]           err_code,
    output logic [CNT_WIDTH-1:0] words_emitted
);

    // {fail, code}; earlier checks take priority over later ones
    function automatic logic [2:0] check_req(input logic [3:0] grp, input logic [3:0] op,
                                             input logic [31:0] imm);
        logic       sext16;
        logic       sext12;
        logic       imm_bad;
        logic [2:0] res;
        sext16  = (imm[31:16] == {16{imm[15]}});
        sext12  = (imm[31:12] == {20{imm[11]}});
        imm_bad = 1'b0;
        case (grp)
            4'd1: begin
                if (op == 4'd3 || op == 4'd5 || op == 4'd14) imm_bad = !sext16;
                else                                         imm_bad = (imm[31:16] != 16'h0000);
            end
            4'd2:    imm_bad = !sext16;
            4'd5:    imm_bad = op[3] && !sext12;
            default: imm_bad = 1'b0;
        endcase
        if (grp >= 4'd7)
            res = 3'b1_00;
        else if ((grp == 4'd2 && op >= 4'd12) ||
                 ((grp == 4'd3 || grp == 4'd4) && op >= 4'd10) ||
                 (grp == 4'd6 && op >= 4'd7))
            res = 3'b1_01;
        else if (imm_bad)
            res = 3'b1_10;
        else
            res = 3'b0_00;
        return res;
    endfunction

    function automatic logic [31:0] encode(input logic [3:0] grp, input logic [3:0] op,
                                           input logic [3:0] ra, input logic [3:0] rb,
                                           input logic [3:0] rc, input logic [31:0] imm);
        logic [31:0] w;
        case (grp)
            4'd1, 4'd2: w = {grp, ra, rb, op, imm[15:0]};
            4'd5:       w = {grp, ra, rb, rc, (op[3] ? imm[11:0] : 12'h000), op};
            default:    w = {grp, ra, rb, rc, 12'h000, op};
        endcase
        return w;
    endfunction

    logic                 out_valid_q, out_valid_d;
    logic [31:0]          out_word_q, out_word_d;
    logic                 out_last_q, out_last_d;
    logic                 err_q, err_d;
    logic [1:0]           err_code_q, err_code_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 idle;
    logic                 accept;
    logic                 out_hs;
    logic [2:0]           chk;

`ifdef INSTR_ENCODER_PSEUDO_LI_EN
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_HI   = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [31:0] hi_word_q, hi_word_d;

    assign idle = (state_q == S_IDLE);
`else
    assign idle = 1'b1;
`endif

    assign in_ready = !rst && idle && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign out_hs   = out_valid_q && out_ready;
    assign chk      = check_req(in_group, in_opcode, in_imm);

    always_comb begin
        out_valid_d = out_valid_q && !out_ready;
        out_word_d  = out_word_q;
        out_last_d  = out_last_q;
        err_d       = 1'b0;
        err_code_d  = err_code_q;
        cnt_d       = out_hs ? cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1} : cnt_q;
`ifdef INSTR_ENCODER_PSEUDO_LI_EN
        state_d     = state_q;
        hi_word_d   = hi_word_q;
        // Cpyhi half goes out as soon as the Addi half is taken
        if (state_q == S_HI && out_hs) begin
            out_valid_d = 1'b1;
            out_word_d  = hi_word_q;
            out_last_d  = 1'b1;
            state_d     = S_IDLE;
        end
`endif
        if (accept) begin
            if (in_pseudo_li) begin
`ifdef INSTR_ENCODER_PSEUDO_LI_EN
                out_valid_d = 1'b1;
                out_word_d  = {4'h1, in_ra, 4'h0, 4'h0, in_imm[15:0]};
                out_last_d  = (in_imm[31:16] == 16'h0000);
                if (in_imm[31:16] != 16'h0000) begin
                    state_d   = S_HI;
                    hi_word_d = {4'h1, in_ra, 4'h0, 4'hF, in_imm[31:16]};
                end
`else
                err_d      = 1'b1;
                err_code_d = 2'd3;
`endif
            end else if (chk[2]) begin
                err_d      = 1'b1;
                err_code_d = chk[1:0];
            end else begin
                out_valid_d = 1'b1;
                out_word_d  = encode(in_group, in_opcode, in_ra, in_rb, in_rc, in_imm);
                out_last_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_word_q  <= 32'h0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= 2'd0;
            cnt_q       <= '0;
`ifdef INSTR_ENCODER_PSEUDO_LI_EN
            state_q     <= S_IDLE;
            hi_word_q   <= 32'h0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            out_word_q  <= out_word_d;
            out_last_q  <= out_last_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            cnt_q       <= cnt_d;
`ifdef INSTR_ENCODER_PSEUDO_LI_EN
            state_q     <= state_d;
            hi_word_q   <= hi_word_d;
`endif
        end
    end

    assign out_valid     = out_valid_q;
    assign out_word      = out_word_q;
    assign out_last      = out_last_q;
    assign err           = err_q;
    assign err_code      = err_code_q;
    assign words_emitted = cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed vector table, stall/reset sequences, random vs reference model.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_group, in_opcode, in_ra, in_rb, in_rc;
    logic [31:0] in_imm;
    logic        in_pseudo_li;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic        out_last;
    logic        err;
    logic [1:0]  err_code;
    logic [15:0] words_emitted;

    instr_encoder #(.CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_group(in_group), .in_opcode(in_opcode),
        .in_ra(in_ra), .in_rb(in_rb), .in_rc(in_rc),
        .in_imm(in_imm), .in_pseudo_li(in_pseudo_li),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_word(out_word), .out_last(out_last),
        .err(err), .err_code(err_code),
        .words_emitted(words_emitted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  grp;
        logic [3:0]  op;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [3:0]  rc;
        logic [31:0] imm;
        logic        pseudo;
    } req_t;

    typedef struct {
        logic        is_err;
        logic [1:0]  code;
        int          nwords;
        logic [31:0] w0;
        logic [31:0] w1;
    } exp_t;

    typedef struct {
        req_t r;
        exp_t e;
    } vec_t;

    vec_t tbl[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   exp_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    function automatic req_t mk_req(input int g, input int op, input int ra, input int rb,
                                    input int rc, input logic [31:0] imm, input logic ps);
        req_t r;
        r.grp = 4'(g); r.op = 4'(op); r.ra = 4'(ra); r.rb = 4'(rb); r.rc = 4'(rc);
        r.imm = imm; r.pseudo = ps;
        return r;
    endfunction

    function automatic exp_t mk_exp(input logic e, input int code, input int nw,
                                    input logic [31:0] w0, input logic [31:0] w1);
        exp_t x;
        x.is_err = e; x.code = 2'(code); x.nwords = nw; x.w0 = w0; x.w1 = w1;
        return x;
    endfunction

    task automatic add_vec(input req_t r, input exp_t e);
        vec_t v;
        v.r = r; v.e = e;
        tbl.push_back(v);
    endtask

    // Reference model: field arithmetic straight from the instruction format rules
    function automatic exp_t model(input req_t r);
        exp_t        x;
        longint      s;
        logic        bad_imm;
        logic [31:0] w;
        int          g, op;
        x = mk_exp(1'b0, 0, 1, 32'h0, 32'h0);
        g  = int'(r.grp);
        op = int'(r.op);
        s  = longint'($signed(r.imm));
        if (r.pseudo) begin
`ifdef INSTR_ENCODER_PSEUDO_LI_EN
            x.w0 = 32'h1000_0000 + r.ra * 32'h0100_0000 + (r.imm % 65536);
            if (r.imm / 65536 == 0) x.nwords = 1;
            else begin
                x.nwords = 2;
                x.w1 = 32'h100F_0000 + r.ra * 32'h0100_0000 + (r.imm / 65536);
            end
`else
            x = mk_exp(1'b1, 3, 0, 32'h0, 32'h0);
`endif
            return x;
        end
        if (g >= 7) return mk_exp(1'b1, 0, 0, 32'h0, 32'h0);
        if ((g == 2 && op >= 12) || ((g == 3 || g == 4) && op >= 10) || (g == 6 && op >= 7))
            return mk_exp(1'b1, 1, 0, 32'h0, 32'h0);
        bad_imm = 1'b0;
        if (g == 1 && (op == 3 || op == 5 || op == 14)) bad_imm = (s < -32768 || s > 32767);
        else if (g == 1)                               bad_imm = (r.imm > 32'd65535);
        else if (g == 2)                               bad_imm = (s < -32768 || s > 32767);
        else if (g == 5 && op >= 8)                    bad_imm = (s < -2048 || s > 2047);
        if (bad_imm) return mk_exp(1'b1, 2, 0, 32'h0, 32'h0);
        w = r.grp * 32'h1000_0000 + r.ra * 32'h0100_0000 + r.rb * 32'h0010_0000;
        if (g == 1 || g == 2)      w = w + r.op * 32'h0001_0000 + (r.imm % 65536);
        else if (g == 5 && op >= 8) w = w + r.rc * 32'h0001_0000 + (r.imm % 4096) * 16 + r.op;
        else                       w = w + r.rc * 32'h0001_0000 + r.op;
        x.w0 = w;
        return x;
    endfunction

    task automatic drive_req(input req_t r);
        in_group = r.grp; in_opcode = r.op; in_ra = r.ra; in_rb = r.rb; in_rc = r.rc;
        in_imm = r.imm; in_pseudo_li = r.pseudo;
    endtask

    // Sends one request with out_ready=1 and checks the response against e
    task automatic run_req(input string nm, input req_t r, input exp_t e);
        int waited;
        waited = 0;
        @(negedge clk);
        drive_req(r);
        in_valid = 1'b1;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            chk({nm, "_accept_timeout"}, 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        if (e.is_err) begin
            chk({nm, "_err"}, 32'(err), 32'd1);
            chk({nm, "_err_code"}, 32'(err_code), 32'(e.code));
            chk({nm, "_no_word"}, 32'(out_valid), 32'd0);
        end else begin
            chk({nm, "_no_err"}, 32'(err), 32'd0);
            for (int k = 0; k < e.nwords; k++) begin
                if (k > 0) @(negedge clk);
                chk({nm, "_valid"}, 32'(out_valid), 32'd1);
                chk({nm, "_word"}, out_word, (k == 0) ? e.w0 : e.w1);
                chk({nm, "_last"}, 32'(out_last), (k == e.nwords - 1) ? 32'd1 : 32'd0);
            end
            exp_cnt += e.nwords;
        end
        @(negedge clk);
        chk({nm, "_err_pulse_done"}, 32'(err), 32'd0);
        chk({nm, "_count"}, 32'(words_emitted), 32'(exp_cnt % 65536));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        req_t r;
        exp_t e;
        logic [31:0] bnd[10];
        bnd = '{32'h7FFF, 32'h8000, 32'hFFFF_8000, 32'hFFFF_7FFF, 32'h7FF,
                32'h800, 32'hFFFF_F800, 32'hFFFF_F7FF, 32'hFFFF, 32'h1_0000};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        drive_req(mk_req(0, 0, 0, 0, 0, 32'h0, 1'b0));

        add_vec(mk_req(0, 0, 1, 2, 3, 32'h0, 1'b0),          mk_exp(1'b0, 0, 1, 32'h0123_0000, 32'h0));
        add_vec(mk_req(1, 0, 4, 5, 0, 32'h1234, 1'b0),       mk_exp(1'b0, 0, 1, 32'h1450_1234, 32'h0));
        add_vec(mk_req(1, 3, 1, 2, 0, 32'hFFFF_8000, 1'b0),  mk_exp(1'b0, 0, 1, 32'h1123_8000, 32'h0));
        add_vec(mk_req(1, 3, 1, 2, 0, 32'h0000_8000, 1'b0),  mk_exp(1'b1, 2, 0, 32'h0, 32'h0));
        add_vec(mk_req(5, 8, 1, 2, 3, 32'hFFFF_FFFC, 1'b0),  mk_exp(1'b0, 0, 1, 32'h5123_FFC8, 32'h0));
        add_vec(mk_req(2, 12, 1, 2, 3, 32'h0, 1'b0),         mk_exp(1'b1, 1, 0, 32'h0, 32'h0));
        add_vec(mk_req(7, 0, 1, 2, 3, 32'h0, 1'b0),          mk_exp(1'b1, 0, 0, 32'h0, 32'h0));
        add_vec(mk_req(7, 12, 1, 2, 3, 32'h0001_0000, 1'b0), mk_exp(1'b1, 0, 0, 32'h0, 32'h0));
        add_vec(mk_req(3, 10, 1, 2, 3, 32'h0, 1'b0),         mk_exp(1'b1, 1, 0, 32'h0, 32'h0));
        add_vec(mk_req(5, 3, 2, 3, 4, 32'hFFFF_FFFF, 1'b0),  mk_exp(1'b0, 0, 1, 32'h5234_0003, 32'h0));
        add_vec(mk_req(5, 9, 2, 3, 4, 32'h0000_0800, 1'b0),  mk_exp(1'b1, 2, 0, 32'h0, 32'h0));
        add_vec(mk_req(1, 1, 1, 1, 0, 32'h0001_0000, 1'b0),  mk_exp(1'b1, 2, 0, 32'h0, 32'h0));
        add_vec(mk_req(2, 11, 1, 1, 0, 32'hFFFF_8000, 1'b0), mk_exp(1'b0, 0, 1, 32'h211B_8000, 32'h0));
        add_vec(mk_req(6, 6, 15, 14, 13, 32'h0, 1'b0),       mk_exp(1'b0, 0, 1, 32'h6FED_0006, 32'h0));
        add_vec(mk_req(6, 7, 1, 2, 3, 32'h0, 1'b0),          mk_exp(1'b1, 1, 0, 32'h0, 32'h0));
`ifdef INSTR_ENCODER_PSEUDO_LI_EN
        add_vec(mk_req(9, 9, 7, 5, 5, 32'h0000_0042, 1'b1),  mk_exp(1'b0, 0, 1, 32'h1700_0042, 32'h0));
        add_vec(mk_req(0, 0, 7, 0, 0, 32'hDEAD_BEEF, 1'b1),  mk_exp(1'b0, 0, 2, 32'h1700_BEEF, 32'h170F_DEAD));
`else
        add_vec(mk_req(0, 0, 7, 0, 0, 32'h0000_0042, 1'b1),  mk_exp(1'b1, 3, 0, 32'h0, 32'h0));
        add_vec(mk_req(0, 0, 7, 0, 0, 32'hDEAD_BEEF, 1'b1),  mk_exp(1'b1, 3, 0, 32'h0, 32'h0));
`endif

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_word", out_word, 32'h0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_err_code", 32'(err_code), 32'd0);
        chk("rst_count", 32'(words_emitted), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        foreach (tbl[i]) run_req($sformatf("vec%0d", i), tbl[i].r, tbl[i].e);

        // Stall: word held stable, no accept; then back-to-back accept on release
        @(negedge clk);
        out_ready = 1'b0;
        drive_req(mk_req(0, 1, 9, 8, 7, 32'h0, 1'b0));
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        drive_req(mk_req(1, 0, 4, 5, 0, 32'h1234, 1'b0));
        for (int k = 0; k < 3; k++) begin
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_word", out_word, 32'h0987_0001);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        exp_cnt += 1;
        chk("b2b_valid", 32'(out_valid), 32'd1);
        chk("b2b_word", out_word, 32'h1450_1234);
        chk("b2b_count", 32'(words_emitted), 32'(exp_cnt));
        @(negedge clk);
        exp_cnt += 1;
        chk("b2b_count2", 32'(words_emitted), 32'(exp_cnt));

`ifdef INSTR_ENCODER_PSEUDO_LI_EN
        // li with output stalled three cycles
        out_ready = 1'b0;
        drive_req(mk_req(0, 0, 7, 0, 0, 32'hDEAD_BEEF, 1'b1));
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("li_stall_word0", out_word, 32'h1700_BEEF);
            chk("li_stall_last", 32'(out_last), 32'd0);
            chk("li_stall_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("li_word1", out_word, 32'h170F_DEAD);
        chk("li_word1_last", 32'(out_last), 32'd1);
        chk("li_in_ready_hi", 32'(in_ready), 32'd1);
        @(negedge clk);
        exp_cnt += 2;
        chk("li_count", 32'(words_emitted), 32'(exp_cnt));
        out_ready = 1'b0;
        drive_req(mk_req(0, 0, 3, 0, 0, 32'h1234_5678, 1'b1));
`else
        out_ready = 1'b0;
        drive_req(mk_req(0, 0, 1, 2, 3, 32'h0, 1'b0));
`endif
        // Asynchronous reset with a word pending
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_count", 32'(words_emitted), 32'd0);
        chk("async_rst_in_ready", 32'(in_ready), 32'd0);
        exp_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        run_req("after_rst", mk_req(0, 0, 1, 2, 3, 32'h0, 1'b0), mk_exp(1'b0, 0, 1, 32'h0123_0000, 32'h0));
        chk("after_rst_no_word", 32'(out_valid), 32'd0);

        // Random requests against the reference model
        for (int i = 0; i < 150; i++) begin
            int g;
            g = int'($urandom_range(0, 8));
            if (g == 8) g = int'($urandom_range(8, 15));
            r = mk_req(g, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                       int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 32'h0,
                       ($urandom_range(0, 5) == 0));
            case ($urandom_range(0, 3))
                0:       r.imm = 32'($urandom_range(0, 4095));
                1:       r.imm = 32'h0 - 32'($urandom_range(1, 40000));
                2:       r.imm = $urandom;
                default: r.imm = bnd[$urandom_range(0, 9)];
            endcase
            e = model(r);
            run_req($sformatf("rand%0d", i), r, e);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Streaming instruction encoder; inverse of the core's instruction decoder.
- Accepts field-level requests (group, opcode, register indices, 32-bit immediate) and emits packed 32-bit Frost32 instruction words on a valid/ready stream.
- Used by the debug/boot loader path to write instruction memory. Optionally expands the load-immediate pseudo-op.
- Checks every request for encodability; reports a single error pulse instead of emitting bad words.

Parameters:
CNT_WIDTH, 16, width of the emitted-word counter.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid&&in_ready
in_group  in  4  instruction group (0..6)
in_opcode  in  4  opcode within group
in_ra  in  4  rA index
in_rb  in  4  rB index
in_rc  in  4  rC index
in_imm  in  32  immediate (interpretation per group/opcode)
in_pseudo_li  in  1  request is "li rA, imm32" (group/opcode/rb/rc ignored)
out_valid  out  1  out_word valid
out_ready  in  1  consumer accepts when out_valid&&out_ready
out_word  out  32  encoded instruction
out_last  out  1  out_word is final word of its request
err  out  1  one-cycle error pulse
err_code  out  2  0 bad group, 1 bad opcode, 2 imm out of range, 3 pseudo disabled
words_emitted  out  CNT_WIDTH  count of accepted output words, wraps

Behaviour:
- Reset values: in_ready=0 during rst, then 1. out_valid=0, out_word=0, out_last=0, err=0, err_code=0, words_emitted=0, state=S_IDLE.
- Encodings (bit 31 MSB):
  - Groups 0/3/4/6: {group[31:28], ra[27:24], rb[23:20], rc[19:16], 12'h000[15:4], opcode[3:0]}.
  - Groups 1/2: {group, ra, rb, opcode[19:16], imm16[15:0]}.
  - Group 5: {group, ra, rb, rc, imm12[15:4], opcode[3:0]}. Opcodes 0-7 force imm12=0; opcodes 8-15 use imm[11:0].
- Validity checks (combinational on the request):
  - Bad group: group>=7 -> code 0.
  - Bad opcode -> code 1: group2 op>=12; group3/4 op>=10; group6 op>=7.
  - Imm out of range -> code 2:
    - Group1 signed ops (3, 5, 14): imm must equal sext(imm[15:0]).
    - Other group1 ops: imm[31:16] must be 0.
    - Group2: signed 16-bit.
    - Group5 ops 8-15: imm must equal sext(imm[11:0]).
    - Other groups/opcodes: imm ignored.
  - Priority when several checks fail: code 0 > 1 > 2.
- FSM states: S_IDLE, S_HI.
  - in_ready = (state==S_IDLE) && (!out_valid || out_ready).
  - Accept, valid request: register out_word next cycle, out_valid=1. Latency 1 cycle.
  - Accept, failing request: err=1 for exactly one cycle after accept with err_code; out_valid unchanged; no word emitted.
  - li request, word0 = {4'h1, ra, 4'h0, 4'h0, imm[15:0]} (Addi rA, r0).
    - If imm[31:16]==0: out_last=1 on word0; state stays S_IDLE.
    - Otherwise: out_last=0 on word0; go to S_HI holding word1 = {4'h1, ra, 4'h0, 4'hF, imm[31:16]} (Cpyhi).
    - In S_HI, on word0 handshake, load word1 with out_last=1 and return to S_IDLE.
  - Non-pseudo requests: out_last=1.
- Output stability: out_word/out_last held stable while out_valid&&!out_ready. Back-to-back throughput is one word per cycle when out_ready=1.
- Counter: words_emitted increments on each output handshake; wraps at 2^CNT_WIDTH.
- Asynchronous rst mid-emission (including S_HI): immediately clears all state. The pending word1 is discarded and out_valid drops.

Optional Feature:
INSTR_ENCODER_PSEUDO_LI_EN
- Defined: li expansion as described above.
- Undefined: in_pseudo_li=1 on accept gives err with code 3, emits nothing; S_HI state and word1 register are not built.

Test Plan:
- Three-reg add: group0 op0 ra=1 rb=2 rc=3 -> out_word 0x0123_0000, out_last=1, words_emitted=1.
- Immediate ops: addi group1 op0 ra=4 rb=5 imm=0x1234 -> 0x1450_1234; sltsi op3 ra=1 rb=2 imm=0xFFFF_8000 -> 0x1123_8000; same sltsi with imm=0x0000_8000 -> err=1 code 2, no output.
- Load/store and bad opcode: ldri group5 op8 ra=1 rb=2 rc=3 imm=0xFFFF_FFFC -> 0x5123_FFC8; group2 op12 -> err code 1; group7 -> err code 0.
- li r7,0xDEAD_BEEF with out_ready low 3 cycles (PSEUDO_LI_EN defined):
  - word0 0x1700_BEEF held stable, out_last=0, in_ready=0.
  - Then word1 0x170F_DEAD with out_last=1; words_emitted +2.
- li r7,0x0000_0042 -> single word 0x1700_0042, out_last=1. With the macro undefined -> err code 3.
- Assert rst while in S_HI -> out_valid=0 immediately, words_emitted=0; next request encodes normally.
